// File: rtl/dff_bank_arbiter_if.sv
// Handshake and bank-drive bundle between two writers and dff_bank_arbiter.
// Optional bank-clear signals are present only when DFF_ARB_CLR_EN is defined.
interface dff_bank_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] reg_d;
    logic             reg_en;
    logic             busy;
`ifdef DFF_ARB_CLR_EN
    logic             clr_req;
    logic             reg_clr;
`endif

    // Requester / environment side
    modport master (
`ifdef DFF_ARB_CLR_EN
        output clr_req,
        input  reg_clr,
`endif
        output req0, data0, req1, data1,
        input  gnt0, gnt1, reg_d, reg_en, busy
    );

    // Arbiter side
    modport slave (
`ifdef DFF_ARB_CLR_EN
        input  clr_req,
        output reg_clr,
`endif
        input  req0, data0, req1, data1,
        output gnt0, gnt1, reg_d, reg_en, busy
    );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Two-requester round-robin arbiter sharing one enabled register bank.
// Each grant is bounded to BURST_MAX beats; a beat is a cycle with gntN & reqN.
// Optional feature macro DFF_ARB_CLR_EN adds a one-cycle bank clear (CLR state).
module dff_bank_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BURST_MAX = 4
) (
    input logic               clk,
    input logic               clr,
    dff_bank_arbiter_if.slave bus
);

    localparam logic [3:0] BurstLast = 4'(BURST_MAX - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
`ifdef DFF_ARB_CLR_EN
        StGnt1 = 2'd2,
        StClr  = 2'd3
`else
        StGnt1 = 2'd2
`endif
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic       busy_q, busy_d;
    logic       own_req, oth_req;
`ifdef DFF_ARB_CLR_EN
    logic       pend_q, pend_d;
    logic       clr_go;
`endif

    // Next-state: grant selection, burst counting and fairness pointer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        own_req = 1'b0;
        oth_req = 1'b0;
`ifdef DFF_ARB_CLR_EN
        // clr_req may be a pulse; remember it until the CLR cycle is taken
        clr_go  = pend_q | bus.clr_req;
`endif
        case (state_q)
            StIdle: begin
`ifdef DFF_ARB_CLR_EN
                if (clr_go) begin
                    state_d = StClr;
                end else
`endif
                if (bus.req0 && bus.req1) begin
                    state_d = last_q ? StGnt0 : StGnt1;
                end else if (bus.req0) begin
                    state_d = StGnt0;
                end else if (bus.req1) begin
                    state_d = StGnt1;
                end
            end
            StGnt0, StGnt1: begin
                own_req = (state_q == StGnt0) ? bus.req0 : bus.req1;
                oth_req = (state_q == StGnt0) ? bus.req1 : bus.req0;
                if (own_req) begin
                    cnt_d = cnt_q + 4'd1;
                end
                // Exit on a dropped request or on the beat that completes the burst
                if (!own_req || (cnt_q == BurstLast)) begin
                    cnt_d  = 4'd0;
                    last_d = (state_q == StGnt1);
`ifdef DFF_ARB_CLR_EN
                    if (clr_go) begin
                        state_d = StClr;
                    end else
`endif
                    if (oth_req) begin
                        state_d = (state_q == StGnt0) ? StGnt1 : StGnt0;
                    end else if (own_req) begin
                        state_d = state_q;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
`ifdef DFF_ARB_CLR_EN
        pend_d = clr_go && (state_d != StClr);
`endif
    end

    // State registers; asynchronous clear drops any grant immediately
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
            busy_q  <= 1'b0;
`ifdef DFF_ARB_CLR_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
`ifdef DFF_ARB_CLR_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign bus.gnt0 = (state_q == StGnt0);
    assign bus.gnt1 = (state_q == StGnt1);
    assign bus.busy = busy_q;
`ifdef DFF_ARB_CLR_EN
    assign bus.reg_clr = (state_q == StClr);
`endif

    // Bank drive: data mux and write enable from registered grant and live request
    always_comb begin
        bus.reg_en = 1'b0;
        bus.reg_d  = '0;
        if (state_q == StGnt0) begin
            bus.reg_en = bus.req0;
            bus.reg_d  = bus.data0;
        end else if (state_q == StGnt1) begin
            bus.reg_en = bus.req1;
            bus.reg_d  = bus.data1;
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter with a write scoreboard and a bank model.
// Covers the DFF_ARB_CLR_EN feature when that macro is defined.
module tb_dff_bank_arbiter;

    localparam int unsigned WIDTH = 8;

    logic clk;
    logic clr;
    int   checks   = 0;
    int   failures = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] bank_q;

    dff_bank_arbiter_if #(.WIDTH(WIDTH)) bus ();

    dff_bank_arbiter #(
        .WIDTH    (WIDTH),
        .BURST_MAX(4)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank being arbitrated
    always @(posedge clk) begin
        if (bus.reg_en === 1'b1) bank_q <= bus.reg_d;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every bank write must match the next expected beat
    always @(negedge clk) begin
        if (bus.reg_en === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0)
            else begin
                failures++;
                $error("FAIL unexpected_write observed=%0h expected=none", bus.reg_d);
            end
            if (exp_q.size() != 0) chk("write_data", 32'(bus.reg_d), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        clr       = 1'b0;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.data0 = '0;
        bus.data1 = 8'hA5;
`ifdef DFF_ARB_CLR_EN
        bus.clr_req = 1'b0;
`endif
        #2;
        chk("rst_gnt0", 32'(bus.gnt0), 0);
        chk("rst_gnt1", 32'(bus.gnt1), 0);
        chk("rst_reg_en", 32'(bus.reg_en), 0);
        chk("rst_reg_d", 32'(bus.reg_d), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        tick();
        tick();
        clr = 1'b1;
        mid();
        chk("rel_idle_gnt0", 32'(bus.gnt0), 0);

        // Contention: four beats for requester 0, then zero-gap handoff
        for (int i = 1; i <= 4; i++) begin
            tick();
            bus.data0 = 8'(i);
            exp_q.push_back(8'(i));
            mid();
            chk("cont_gnt0", 32'(bus.gnt0), 1);
            chk("cont_gnt1_low", 32'(bus.gnt1), 0);
            chk("cont_busy", 32'(bus.busy), 1);
        end
        tick();
        bus.req0 = 1'b0;
        exp_q.push_back(8'hA5);
        mid();
        chk("handoff_gnt1", 32'(bus.gnt1), 1);
        chk("handoff_gnt0_low", 32'(bus.gnt0), 0);
        tick();
        exp_q.push_back(8'hA5);
        mid();
        chk("bank_a5", 32'(bank_q), 32'h A5);
        tick();
        bus.req1 = 1'b0;
        mid();
        chk("drop_gnt1_held", 32'(bus.gnt1), 1);
        chk("drop_no_en", 32'(bus.reg_en), 0);
        tick();
        mid();
        chk("drop_gnt1_low", 32'(bus.gnt1), 0);
        chk("drop_busy", 32'(bus.busy), 0);

        // Single requester: burst of four, fresh re-grant, two more beats
        tick();
        bus.req0  = 1'b1;
        bus.data0 = 8'h11;
        mid();
        chk("single_idle", 32'(bus.gnt0), 0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            bus.data0 = 8'(i * 17);
            exp_q.push_back(8'(i * 17));
            mid();
            chk("single_gnt0", 32'(bus.gnt0), 1);
            chk("single_busy", 32'(bus.busy), 1);
        end
        tick();
        bus.req0 = 1'b0;
        mid();
        chk("single_tail_gnt0", 32'(bus.gnt0), 1);
        chk("single_tail_en", 32'(bus.reg_en), 0);
        tick();
        mid();
        chk("single_end_gnt0", 32'(bus.gnt0), 0);
        chk("single_end_busy", 32'(bus.busy), 0);
        chk("bank_66", 32'(bank_q), 32'h66);

        // Asynchronous reset mid-burst
        tick();
        bus.req0  = 1'b1;
        bus.data0 = 8'h77;
        mid();
        tick();
        exp_q.push_back(8'h77);
        mid();
        chk("ar_gnt0", 32'(bus.gnt0), 1);
        tick();
        bus.data0 = 8'h88;
        exp_q.push_back(8'h88);
        mid();
        #2;
        clr = 1'b0;
        #1;
        chk("ar_gnt0_fall", 32'(bus.gnt0), 0);
        chk("ar_en_fall", 32'(bus.reg_en), 0);
        chk("ar_reg_d", 32'(bus.reg_d), 0);
        chk("ar_busy", 32'(bus.busy), 0);
        bus.req1 = 1'b1;
        tick();
        tick();
        clr = 1'b1;
        mid();
        chk("ar_idle_gnt1", 32'(bus.gnt1), 0);
        tick();
        bus.data0 = 8'h99;
        exp_q.push_back(8'h99);
        mid();
        chk("ar_ptr_gnt0", 32'(bus.gnt0), 1);
        chk("ar_ptr_gnt1", 32'(bus.gnt1), 0);
        tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        mid();
        tick();
        mid();
        chk("ar_end_busy", 32'(bus.busy), 0);

`ifdef DFF_ARB_CLR_EN
        // Clear from IDLE beats a pending request
        tick();
        bus.clr_req = 1'b1;
        bus.req0    = 1'b1;
        bus.data0   = 8'hC3;
        mid();
        chk("clr_idle_rc", 32'(bus.reg_clr), 0);
        tick();
        bus.clr_req = 1'b0;
        mid();
        chk("clr_cycle_rc", 32'(bus.reg_clr), 1);
        chk("clr_cycle_en", 32'(bus.reg_en), 0);
        chk("clr_cycle_gnt0", 32'(bus.gnt0), 0);
        tick();
        mid();
        chk("clr_after_rc", 32'(bus.reg_clr), 0);
        tick();
        exp_q.push_back(8'hC3);
        mid();
        chk("clr_then_gnt0", 32'(bus.gnt0), 1);
        tick();
        bus.req0 = 1'b0;
        mid();
        tick();
        bus.req1  = 1'b1;
        bus.data1 = 8'h5A;
        mid();
        // Clear pulse during GNT1 is deferred until the burst exits
        tick();
        bus.clr_req = 1'b1;
        exp_q.push_back(8'h5A);
        mid();
        chk("defer_gnt1", 32'(bus.gnt1), 1);
        tick();
        bus.clr_req = 1'b0;
        exp_q.push_back(8'h5A);
        mid();
        chk("defer_rc_low", 32'(bus.reg_clr), 0);
        tick();
        bus.req1 = 1'b0;
        mid();
        chk("defer_rc_low2", 32'(bus.reg_clr), 0);
        tick();
        mid();
        chk("defer_rc_high", 32'(bus.reg_clr), 1);
        chk("defer_gnt1_low", 32'(bus.gnt1), 0);
        tick();
        mid();
        chk("defer_rc_done", 32'(bus.reg_clr), 0);
        chk("defer_busy", 32'(bus.busy), 0);
`endif

        tick();
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Two-requester round-robin arbiter that shares one WIDTH-bit enabled register bank (a row of d_ff cells: d, clr, clk, en, q) between two writers. It grants the bank with a valid/grant handshake, drives the bank's data and enable, and bounds each grant to BURST_MAX beats for fairness. It sits between the requesting datapath blocks and the register bank; the bank's q outputs go straight to readers.

## Interface
- WIDTH, 8: data width of the shared register bank.
- BURST_MAX, 4: maximum beats per grant (1..15); counter width 4 bits.
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous reset, active-low.
- req0  input  1  requester 0 write request; data0 valid while high.
- data0  input  WIDTH  requester 0 write data.
- req1  input  1  requester 1 write request.
- data1  input  WIDTH  requester 1 write data.
- gnt0  output  1  registered grant to requester 0.
- gnt1  output  1  registered grant to requester 1.
- reg_d  output  WIDTH  data to bank d inputs.
- reg_en  output  1  bank enable; one bank write per clk edge while high.
- busy  output  1  registered; high when state is not IDLE.

## Operation
- States: IDLE, GNT0, GNT1 (plus CLR under the macro). gnt0 = (state==GNT0), gnt1 = (state==GNT1); at most one grant high, ever.
- Beat: clock edge ending a cycle with gntN=1 and reqN=1. reg_en = (gnt0&req0)|(gnt1&req1); reg_d = data0 when gnt0, data1 when gnt1, else all zeros. Both are combinational from registered state and inputs.
- Pointer last (1 bit) records the most recently granted requester.
- IDLE: req0 only -> GNT0; req1 only -> GNT1; both -> requester != last; neither -> stay.
- GNTx: beat count cnt increments per beat. Exit when reqx is low, or when the beat that makes cnt==BURST_MAX occurs. On exit: set last=x, clear cnt. If the other requester is requesting, go directly to GNTy. Otherwise, if reqx is still high, go to GNTx again with a fresh burst. Otherwise, go to IDLE.
- Requester rule: reqN may drop only after a beat or while gntN is low. dataN must be stable while reqN=1 and gntN=1.

## Timing
- Reset (clr=0, asynchronous): state=IDLE, gnt0=gnt1=0, busy=0, cnt=0, last=1 (requester 0 wins first tie). reg_en=0 and reg_d=0 follow immediately. Reset mid-burst drops the grant without waiting for clk.
- Latency: request seen in IDLE at edge k -> gnt high in cycle k+1 -> first bank write at edge k+2. Bank q updates one cycle after the beat.
- Throughput: one beat per cycle within a burst. Handoff GNTx->GNTy costs zero idle cycles. IDLE->grant costs one cycle.
- Burst exit with the other requester pending: the granted requester's gnt is low in the next cycle even if its req stays high. It is re-served after the other requester's burst.
- gnt with req low for one cycle: no write, exit next edge.

## Configuration
- DFF_ARB_CLR_EN defined: adds input clr_req (1 bit) and output reg_clr (1 bit, active-high, to the bank clr).
  - From IDLE, clr_req has priority over both requests -> CLR for exactly one cycle. reg_clr=1 and reg_en=0 in that cycle, then IDLE.
  - A clr_req raised during GNTx waits for the burst exit, then CLR precedes any handoff. last is unchanged.
  - reg_clr resets to 0.
- DFF_ARB_CLR_EN undefined: no clr_req or reg_clr ports, no CLR state. The bank clr is tied inactive by the integrator.

## Test plan
- Reset: clr=0 with req0=req1=1 -> gnt0=gnt1=reg_en=0, reg_d=0. Release clr -> gnt0=1 the next cycle (last=1 favours requester 0).
- Single burst: BURST_MAX=4, req0 held 6 cycles, data0 = 0x11, 0x22, ... -> beats 1-4 write 0x11-0x44 with reg_en=1. Re-grant to requester 0, then 0x55 and 0x66 written. busy stays 1 throughout.
- Contention: req0 and req1 both held, data1=0xA5 -> 4 beats for requester 0, then gnt1 the next cycle with no idle gap. Bank q reads 0xA5 after requester 1's first beat.
- Early drop: req1 low after 2 beats -> gnt1 low the next cycle, cnt cleared, IDLE, busy=0. Exactly 2 reg_en pulses.
- Async reset mid-burst: clr pulsed low between edges during GNT0 -> gnt0 and reg_en fall immediately, no further writes, pointer back to 1.
- DFF_ARB_CLR_EN: clr_req with req0 in IDLE -> one cycle reg_clr=1, reg_en=0, then gnt0. clr_req during GNT1 -> deferred until burst exit.
